pa_secretkey_stream_out: RTL and testbench

//  Downstream sink for one PA engine's (Alice or Bob) secret-key BRAM port-B write stream.

---
 rtl/pa_secretkey_stream_out_pkg.sv | 21 ++
 rtl/pa_secretkey_stream_out_key_fifo.sv | 61 ++++++
 rtl/pa_secretkey_stream_out.sv | 161 ++++++++++++++++
 tb/tb_pa_secretkey_stream_out.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_secretkey_stream_out_pkg.sv
// Shared definitions for the PA secret-key output stream: FSM states and widths.
package pa_secretkey_stream_out_pkg;

  localparam int unsigned KEY_ADDR_W = 15;
  localparam int unsigned KEY_DATA_W = 64;
  localparam int unsigned KEY_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } pa_state_e;

  // States in which a start pulse is accepted and arms a new block.
  function automatic logic is_armable(input pa_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/pa_secretkey_stream_out_key_fifo.sv
// Synchronous first-word-fall-through FIFO for 64-bit key words.
module pa_key_fifo
  import pa_secretkey_stream_out_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = KEY_DATA_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A push into a full FIFO succeeds when a pop frees a slot on the same edge.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pa_secretkey_stream_out.sv
// Sink for a PA engine's secret-key port-B writes: buffers words, re-emits them as a
// valid/ready stream with tlast, and checks address continuity and word count.
module pa_secretkey_stream_out
  import pa_secretkey_stream_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = KEY_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KEY_CNT_W-1:0]  key_words,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [KEY_DATA_W-1:0] key_dinb,
  input  logic [ADDR_W-1:0]     key_addrb,
  input  logic                  key_enb,
  input  logic                  key_web,
  input  logic                  pa_fail,
  output logic [KEY_DATA_W-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  done,
  output logic                  fail,
  output logic                  addr_err,
  output logic                  ovf_err,
  output logic [KEY_CNT_W-1:0]  words_out
);

  pa_state_e              r_state;
  logic [KEY_CNT_W-1:0]   r_key_words;
  logic [KEY_CNT_W-1:0]   r_wr_cnt;
  logic [KEY_CNT_W-1:0]   r_words_out;
  logic [ADDR_W-1:0]      r_base;
  logic                   r_armed;
  logic                   r_done;
  logic                   r_fail;
  logic                   r_addr_err;
  logic                   r_ovf_err;

  logic                   w_wr;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_flush;
  logic                   w_start_ok;
  logic                   w_collecting;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [KEY_DATA_W-1:0]  w_fifo_dout;
  logic [ADDR_W-1:0]      w_exp_addr;

  assign w_wr         = key_enb && key_web;
  assign w_collecting = (r_state == ST_COLLECT) || (r_state == ST_DRAIN);
  assign w_start_ok   = start && is_armable(r_state);
  assign w_push       = (r_state == ST_COLLECT) && w_wr && !pa_fail;
  assign w_flush      = w_start_ok || (pa_fail && w_collecting);
  assign w_exp_addr   = r_base + ADDR_W'(r_wr_cnt);

  pa_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_DATA_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (key_dinb),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_tvalid  = !w_fifo_empty;
  assign m_tdata   = w_fifo_empty ? '0 : w_fifo_dout;
  assign m_tlast   = m_tvalid && (r_words_out == r_key_words - KEY_CNT_W'(1));
  assign w_pop     = m_tvalid && m_tready;

  assign done      = r_done;
  assign fail      = r_fail;
  assign addr_err  = r_addr_err;
  assign ovf_err   = r_ovf_err;
  assign words_out = r_words_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_key_words <= '0;
      r_wr_cnt    <= '0;
      r_words_out <= '0;
      r_base      <= '0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_addr_err  <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_words_out <= r_words_out + KEY_CNT_W'(1);
      end
      unique case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            r_key_words <= key_words;
            r_base      <= base_addr;
            r_wr_cnt    <= '0;
            r_words_out <= '0;
            r_addr_err  <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_fail      <= 1'b0;
            r_armed     <= 1'b1;
            if (key_words == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_COLLECT;
              r_done  <= 1'b0;
            end
          end else if (w_wr && r_armed) begin
            r_ovf_err <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (pa_fail) begin
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
          end else if (w_wr) begin
            if (key_addrb != w_exp_addr) begin
              r_addr_err <= 1'b1;
            end
            // Count follows the PA even when the word itself is dropped.
            if (w_fifo_full && !w_pop) begin
              r_ovf_err <= 1'b1;
            end
            r_wr_cnt <= r_wr_cnt + KEY_CNT_W'(1);
            if (r_wr_cnt + KEY_CNT_W'(1) == r_key_words) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pa_fail) begin
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
          end else begin
            if (w_wr) begin
              r_ovf_err <= 1'b1;
            end
            // An empty FIFO also ends the block, so dropped words cannot stall it.
            if ((r_words_out == r_key_words) || w_fifo_empty) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_secretkey_stream_out.sv
// Directed bench for pa_secretkey_stream_out with a queue of expected output words.
module tb_pa_secretkey_stream_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] key_words;
  logic [14:0] base_addr;
  logic [63:0] key_dinb;
  logic [14:0] key_addrb;
  logic        key_enb;
  logic        key_web;
  logic        pa_fail;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        done;
  logic        fail;
  logic        addr_err;
  logic        ovf_err;
  logic [15:0] words_out;

  int          checks   = 0;
  int          failures = 0;
  int          beat_idx = 0;
  int          cur_kw   = 0;
  logic [63:0] expq[$];

  pa_secretkey_stream_out #(.FIFO_DEPTH(16), .ADDR_W(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_words (key_words),
    .base_addr (base_addr),
    .key_dinb  (key_dinb),
    .key_addrb (key_addrb),
    .key_enb   (key_enb),
    .key_web   (key_web),
    .pa_fail   (pa_fail),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .done      (done),
    .fail      (fail),
    .addr_err  (addr_err),
    .ovf_err   (ovf_err),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] kd(input int t, input int i);
    return {16'hC0DE, t[15:0], i[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; scores any beat transferred on that edge and checks stall stability.
  task automatic tick();
    logic        pv, pr, pl, pf;
    logic [63:0] pd;
    pv = m_tvalid; pr = m_tready; pl = m_tlast; pd = m_tdata;
    pf = rst || pa_fail || start;
    @(posedge clk); #1;
    if (pv && pr) begin
      if (expq.size() == 0) begin
        chk("beat_in_queue", 64'(expq.size()), 64'd1);
      end else begin
        chk("beat_data", pd, expq.pop_front());
        chk("beat_tlast", 64'(pl), 64'(beat_idx == cur_kw - 1));
      end
      beat_idx++;
    end else if (pv && !pr && !pf) begin
      chk("stall_valid", 64'(m_tvalid), 64'd1);
      chk("stall_data", m_tdata, pd);
      chk("stall_last", 64'(m_tlast), 64'(pl));
    end
  endtask

  task automatic do_start(input int kw, input int base);
    key_words = 16'(kw);
    base_addr = 15'(base);
    cur_kw    = kw;
    beat_idx  = 0;
    expq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [63:0] data, input bit kept);
    key_addrb = 15'(addr);
    key_dinb  = data;
    key_enb   = 1'b1;
    key_web   = 1'b1;
    if (kept) expq.push_back(data);
    tick();
    key_enb = 1'b0;
    key_web = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int n = 0; n < max_cycles && !done; n++) tick();
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; key_words = '0; base_addr = '0;
    key_dinb = '0; key_addrb = '0; key_enb = 1'b0; key_web = 1'b0;
    pa_fail = 1'b0; m_tready = 1'b0;
    tick(); tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_words_out", 64'(words_out), 64'd0);
    rst = 1'b0;
    tick();

    // 1: 64 sequential words at full rate
    do_start(64, 0);
    m_tready = 1'b1;
    for (int i = 0; i < 64; i++) wr(i, kd(1, i), 1'b1);
    wait_done(10);
    chk("t1_beats", 64'(beat_idx), 64'd64);
    chk("t1_words_out", 64'(words_out), 64'd64);
    chk("t1_addr_err", 64'(addr_err), 64'd0);
    chk("t1_ovf_err", 64'(ovf_err), 64'd0);
    chk("t1_tvalid_idle", 64'(m_tvalid), 64'd0);

    // 2: upper half base, tready toggling every cycle
    do_start(32, 16384);
    w = 0;
    for (int c = 0; w < 32; c++) begin
      m_tready = !m_tready;
      if (c % 3 != 2) begin
        wr(16384 + w, kd(2, w), 1'b1);
        w++;
      end else begin
        tick();
      end
    end
    for (int n = 0; n < 100 && !done; n++) begin
      m_tready = !m_tready;
      tick();
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_words_out", 64'(words_out), 64'd32);
    chk("t2_beats", 64'(beat_idx), 64'd32);
    chk("t2_addr_err", 64'(addr_err), 64'd0);
    chk("t2_ovf_err", 64'(ovf_err), 64'd0);

    // 3: 20 writes into a stalled 16-deep FIFO
    do_start(20, 0);
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr(i, kd(3, i), i < 16);
      if (i == 15) chk("t3_ovf_before_full", 64'(ovf_err), 64'd0);
      if (i == 16) chk("t3_ovf_on_drop", 64'(ovf_err), 64'd1);
    end
    chk("t3_head_word", m_tdata, kd(3, 0));
    m_tready = 1'b1;
    wait_done(40);
    chk("t3_beats", 64'(beat_idx), 64'd16);
    chk("t3_words_out", 64'(words_out), 64'd16);
    chk("t3_ovf_sticky", 64'(ovf_err), 64'd1);
    chk("t3_queue_empty", 64'(expq.size()), 64'd0);

    // 4: address gap 0,1,3
    do_start(3, 0);
    m_tready = 1'b1;
    wr(0, kd(4, 0), 1'b1);
    chk("t4_addr_ok0", 64'(addr_err), 64'd0);
    wr(1, kd(4, 1), 1'b1);
    chk("t4_addr_ok1", 64'(addr_err), 64'd0);
    wr(3, kd(4, 2), 1'b1);
    chk("t4_addr_err", 64'(addr_err), 64'd1);
    wait_done(10);
    chk("t4_beats", 64'(beat_idx), 64'd3);
    chk("t4_words_out", 64'(words_out), 64'd3);

    // 5: PA abort after 10 writes, beat taken on the abort cycle
    do_start(64, 0);
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) wr(i, kd(5, i), 1'b1);
    m_tready = 1'b1;
    pa_fail  = 1'b1;
    tick();
    pa_fail = 1'b0;
    expq.delete();
    chk("t5_fail", 64'(fail), 64'd1);
    chk("t5_tvalid_off", 64'(m_tvalid), 64'd0);
    chk("t5_words_out", 64'(words_out), 64'd1);
    chk("t5_done", 64'(done), 64'd0);
    tick();
    chk("t5_tvalid_still_off", 64'(m_tvalid), 64'd0);
    do_start(4, 0);
    chk("t5_fail_cleared", 64'(fail), 64'd0);
    chk("t5_words_cleared", 64'(words_out), 64'd0);
    for (int i = 0; i < 4; i++) wr(i, kd(6, i), 1'b1);
    wait_done(10);
    chk("t5_restart_beats", 64'(beat_idx), 64'd4);
    chk("t5_restart_fail", 64'(fail), 64'd0);

    // 6: empty block, write while DONE, reset mid-COLLECT
    do_start(0, 0);
    tick();
    chk("t6_done_zero", 64'(done), 64'd1);
    chk("t6_no_beats", 64'(words_out), 64'd0);
    chk("t6_ovf_before", 64'(ovf_err), 64'd0);
    wr(5, kd(7, 0), 1'b0);
    chk("t6_ovf_done_write", 64'(ovf_err), 64'd1);
    do_start(8, 0);
    for (int i = 0; i < 3; i++) wr(i, kd(8, i), 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_fail", 64'(fail), 64'd0);
    chk("t6_rst_addr_err", 64'(addr_err), 64'd0);
    chk("t6_rst_ovf_err", 64'(ovf_err), 64'd0);
    chk("t6_rst_words_out", 64'(words_out), 64'd0);
    chk("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_tlast", 64'(m_tlast), 64'd0);
    chk("t6_rst_tdata", m_tdata, 64'd0);
    wr(0, kd(9, 0), 1'b0);
    chk("t6_unarmed_write", 64'(ovf_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
